// File: rtl/regfile_wb_arbiter_if.sv
// Writeback / scoreboard bus for regfile_wb_arbiter.
//   A requester : a_valid, a_reg, a_data  -> a_ready
//   M requester : m_valid, m_reg, m_data  -> m_ready
//   Decode      : issue_valid, issue_reg, src1_reg, src2_reg -> issue_stall, src_hazard
//   Regfile     : WriteReg, DstReg, DstData (write port), busy (pending bits)
// master = requesters/decode side, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  localparam int NREG = 2**REG_W;

  logic              a_valid;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              m_valid;
  logic [REG_W-1:0]  m_reg;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              issue_valid;
  logic [REG_W-1:0]  issue_reg;
  logic              issue_stall;
  logic [REG_W-1:0]  src1_reg;
  logic [REG_W-1:0]  src2_reg;
  logic              src_hazard;
  logic              WriteReg;
  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic [NREG-1:0]   busy;

  modport master (
    output a_valid, a_reg, a_data, m_valid, m_reg, m_data,
           issue_valid, issue_reg, src1_reg, src2_reg,
    input  a_ready, m_ready, issue_stall, src_hazard,
           WriteReg, DstReg, DstData, busy
  );

  modport slave (
    input  a_valid, a_reg, a_data, m_valid, m_reg, m_data,
           issue_valid, issue_reg, src1_reg, src2_reg,
    output a_ready, m_ready, issue_stall, src_hazard,
           WriteReg, DstReg, DstData, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load (M) writeback paths, with a registered 1-cycle write stage and a
// per-register pending-write scoreboard for decode hazard detection.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - regfile_wb_arbiter_if.slave (requests, decode queries, write port, busy)
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**REG_W;

  typedef enum logic {GNT_A = 1'b0, GNT_M = 1'b1} gnt_e;

  gnt_e              last_q, last_d;
  logic              wr_q, wr_d;
  logic [REG_W-1:0]  dreg_q, dreg_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic gnt_a, gnt_m, stall, hz1, hz2;

  // A register being written this cycle is forwarded by the regfile, so it
  // no longer counts as pending.
  function automatic logic pending(input logic [REG_W-1:0] r);
    return busy_q[r] & ~(wr_q & (dreg_q == r));
  endfunction

  // Tie goes to whoever did not win last; a lone request always wins.
  always_comb begin
    gnt_a = bus.a_valid & (~bus.m_valid | (last_q == GNT_M));
    gnt_m = bus.m_valid & (~bus.a_valid | (last_q == GNT_A));
  end

  assign stall = bus.issue_valid & pending(bus.issue_reg);
  assign hz1   = pending(bus.src1_reg);
  assign hz2   = pending(bus.src2_reg);

  always_comb begin
    last_d  = last_q;
    wr_d    = gnt_a | gnt_m;
    dreg_d  = dreg_q;
    ddata_d = ddata_q;
    if (gnt_a) begin
      last_d  = GNT_A;
      dreg_d  = bus.a_reg;
      ddata_d = bus.a_data;
    end else if (gnt_m) begin
      last_d  = GNT_M;
      dreg_d  = bus.m_reg;
      ddata_d = bus.m_data;
    end
    // Clear first so a same-cycle set on the same register wins.
    busy_d = busy_q;
    if (wr_q) busy_d[dreg_q] = 1'b0;
    if (bus.issue_valid & ~stall) busy_d[bus.issue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q  <= GNT_M;
      wr_q    <= 1'b0;
      dreg_q  <= '0;
      ddata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      wr_q    <= wr_d;
      dreg_q  <= dreg_d;
      ddata_q <= ddata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.a_ready     = gnt_a;
  assign bus.m_ready     = gnt_m;
  assign bus.issue_stall = stall;
  assign bus.src_hazard  = hz1 | hz2;
  assign bus.WriteReg    = wr_q;
  assign bus.DstReg      = dreg_q;
  assign bus.DstData     = ddata_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .REG_W(RW)) bus();
  regfile_wb_arbiter #(.DATA_W(DW), .REG_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: who won last, the write in flight, set of pending regs.
  bit          m_last_a;
  bit          m_wr;
  bit [RW-1:0] m_dreg;
  bit [DW-1:0] m_ddata;
  bit          m_busy [NR];

  typedef struct {
    logic          av; logic [RW-1:0] ar; logic [DW-1:0] ad;
    logic          mv; logic [RW-1:0] mr; logic [DW-1:0] md;
    logic          e_ar, e_mr, e_wr;
    logic [RW-1:0] e_dr; logic [DW-1:0] e_dd;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_pend(input logic [RW-1:0] r);
    return m_busy[r] && !(m_wr && m_dreg == r);
  endfunction

  function automatic bit m_ga();
    if (bus.a_valid && bus.m_valid) return !m_last_a;
    return bus.a_valid;
  endfunction

  function automatic bit m_gm();
    if (bus.a_valid && bus.m_valid) return m_last_a;
    return bus.m_valid;
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    m_last_a = 1'b0; m_wr = 1'b0; m_dreg = '0; m_ddata = '0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  task automatic idle();
    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.m_valid = 0; bus.m_reg = 0; bus.m_data = 0;
    bus.issue_valid = 0; bus.issue_reg = 0;
    bus.src1_reg = 0; bus.src2_reg = 0;
  endtask

  // Advance model with current inputs, then cross the clock edge.
  task automatic tick();
    bit ga, gm, st;
    if (!rst) m_reset();
    else begin
      ga = m_ga(); gm = m_gm();
      st = bus.issue_valid && m_pend(bus.issue_reg);
      if (m_wr) m_busy[m_dreg] = 1'b0;
      if (bus.issue_valid && !st) m_busy[bus.issue_reg] = 1'b1;
      if (ga) begin m_dreg = bus.a_reg; m_ddata = bus.a_data; m_last_a = 1'b1; end
      else if (gm) begin m_dreg = bus.m_reg; m_ddata = bus.m_data; m_last_a = 1'b0; end
      m_wr = ga || gm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, ".a_ready"},     32'(bus.a_ready),     32'(m_ga()));
    chk({tag, ".m_ready"},     32'(bus.m_ready),     32'(m_gm()));
    chk({tag, ".WriteReg"},    32'(bus.WriteReg),    32'(m_wr));
    if (m_wr) begin
      chk({tag, ".DstReg"},    32'(bus.DstReg),      32'(m_dreg));
      chk({tag, ".DstData"},   32'(bus.DstData),     32'(m_ddata));
    end
    chk({tag, ".busy"},        32'(bus.busy),        32'(m_busy_vec()));
    chk({tag, ".issue_stall"}, 32'(bus.issue_stall),
        32'(bus.issue_valid && m_pend(bus.issue_reg)));
    chk({tag, ".src_hazard"},  32'(bus.src_hazard),
        32'(m_pend(bus.src1_reg) || m_pend(bus.src2_reg)));
  endtask

  initial begin
    bit a_hold, m_hold;

    // Single write, then an M-only write so the tie sequence starts with A.
    vecs[0] = '{1, 3, 16'h1234, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0};
    vecs[1] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 3, 16'h1234};
    vecs[2] = '{0, 0, 16'h0,    1, 4, 16'h0404, 0, 1, 0, 3, 16'h1234};
    vecs[3] = '{1, 1, 16'hAAAA, 1, 2, 16'h5555, 1, 0, 1, 4, 16'h0404};
    vecs[4] = '{1, 1, 16'hAAAB, 1, 2, 16'h5555, 0, 1, 1, 1, 16'hAAAA};
    vecs[5] = '{1, 1, 16'hAAAB, 1, 2, 16'h5556, 1, 0, 1, 2, 16'h5555};
    vecs[6] = '{1, 1, 16'hAAAC, 1, 2, 16'h5556, 0, 1, 1, 1, 16'hAAAB};
    vecs[7] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 2, 16'h5556};
    vecs[8] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 2, 16'h5556};

    idle();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    m_reset();
    chk("rst.WriteReg", 32'(bus.WriteReg), 32'd0);
    chk("rst.DstReg",   32'(bus.DstReg),   32'd0);
    chk("rst.DstData",  32'(bus.DstData),  32'd0);
    chk("rst.busy",     32'(bus.busy),     32'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.a_valid = vecs[i].av; bus.a_reg = vecs[i].ar; bus.a_data = vecs[i].ad;
      bus.m_valid = vecs[i].mv; bus.m_reg = vecs[i].mr; bus.m_data = vecs[i].md;
      #1;
      chk($sformatf("vec%0d.a_ready", i),  32'(bus.a_ready),  32'(vecs[i].e_ar));
      chk($sformatf("vec%0d.m_ready", i),  32'(bus.m_ready),  32'(vecs[i].e_mr));
      chk($sformatf("vec%0d.WriteReg", i), 32'(bus.WriteReg), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d.DstReg", i),   32'(bus.DstReg),   32'(vecs[i].e_dr));
      chk($sformatf("vec%0d.DstData", i),  32'(bus.DstData),  32'(vecs[i].e_dd));
      tick();
    end

    // RAW: issue 5, hazard on src1, forwarded during the write, clear after.
    idle(); bus.issue_valid = 1; bus.issue_reg = 5; #1;
    chk("raw.issue_stall", 32'(bus.issue_stall), 32'd0);
    tick();
    idle(); bus.src1_reg = 5; bus.m_valid = 1; bus.m_reg = 5; bus.m_data = 16'h0555; #1;
    chk("raw.busy5",   32'(bus.busy[5]),    32'd1);
    chk("raw.hazard",  32'(bus.src_hazard), 32'd1);
    chk("raw.m_ready", 32'(bus.m_ready),    32'd1);
    tick();
    idle(); bus.src2_reg = 5; #1;
    chk("raw.fwd_wr",     32'(bus.WriteReg),   32'd1);
    chk("raw.fwd_hazard", 32'(bus.src_hazard), 32'd0);
    tick();
    #1;
    chk("raw.busy5_clr", 32'(bus.busy[5]), 32'd0);

    // WAW: stall on pending 7, no stall when the write completes, set wins.
    idle(); bus.issue_valid = 1; bus.issue_reg = 7; tick();
    idle(); bus.issue_valid = 1; bus.issue_reg = 7; #1;
    chk("waw.stall", 32'(bus.issue_stall), 32'd1);
    tick(); #1;
    chk("waw.busy", 32'(bus.busy), 32'h0080);
    idle(); bus.a_valid = 1; bus.a_reg = 7; bus.a_data = 16'h7777; tick();
    idle(); bus.issue_valid = 1; bus.issue_reg = 7; #1;
    chk("waw.wr_stall", 32'(bus.issue_stall), 32'd0);
    chk("waw.DstReg",   32'(bus.DstReg),      32'd7);
    tick(); #1;
    chk("waw.set_wins", 32'(bus.busy[7]), 32'd1);

    // Reset mid-operation drops the in-flight write and the scoreboard.
    idle(); bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 16'hBEEF;
    bus.issue_valid = 1; bus.issue_reg = 4; tick();
    idle(); rst = 1'b0; tick();
    chk("rst2.WriteReg", 32'(bus.WriteReg), 32'd0);
    chk("rst2.busy",     32'(bus.busy),     32'd0);
    rst = 1'b1;
    bus.a_valid = 1; bus.a_reg = 1; bus.m_valid = 1; bus.m_reg = 2; #1;
    chk("rst2.tie_a", 32'(bus.a_ready), 32'd1);
    chk("rst2.tie_m", 32'(bus.m_ready), 32'd0);
    tick();

    // Three back-to-back A writes to reg 9.
    for (int k = 0; k < 3; k++) begin
      idle(); bus.a_valid = 1; bus.a_reg = 9; bus.a_data = 16'h9000 + 16'(k); tick();
      chk($sformatf("r9.wr%0d", k), 32'(bus.WriteReg), 32'd1);
      chk($sformatf("r9.dr%0d", k), 32'(bus.DstReg),   32'd9);
      chk($sformatf("r9.dd%0d", k), 32'(bus.DstData),  32'h9000 + 32'(k));
    end
    idle(); tick();

    // Random traffic against the model; requesters hold until accepted.
    a_hold = 0; m_hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_hold) begin
        bus.a_valid = ($urandom_range(0, 99) < 60);
        bus.a_reg   = RW'($urandom_range(0, 7));
        bus.a_data  = DW'($urandom);
      end
      if (!m_hold) begin
        bus.m_valid = ($urandom_range(0, 99) < 50);
        bus.m_reg   = RW'($urandom_range(0, 7));
        bus.m_data  = DW'($urandom);
      end
      bus.issue_valid = ($urandom_range(0, 99) < 35);
      bus.issue_reg   = RW'($urandom_range(0, 7));
      bus.src1_reg    = RW'($urandom_range(0, 7));
      bus.src2_reg    = RW'($urandom_range(0, 15));
      check_model($sformatf("rnd%0d", c));
      a_hold = bus.a_valid && !m_ga();
      m_hold = bus.m_valid && !m_gm();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (DstReg/DstData/WriteReg) between two writeback requesters: ALU path (A) and memory/load path (M).
- Arbitrates round-robin and drives a registered write stage into the 16x16 register file.
- Keeps a per-register pending-write scoreboard so decode can detect RAW/WAW hazards against in-flight writes.

Parameters:
- DATA_W, 16, register data width
- REG_W, 4, register index width; NREG = 2**REG_W = 16 registers

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- a_valid  in  1  ALU writeback request
- a_reg  in  REG_W  ALU destination register
- a_data  in  DATA_W  ALU result
- a_ready  out  1  ALU request accepted this cycle
- m_valid  in  1  memory writeback request
- m_reg  in  REG_W  memory destination register
- m_data  in  DATA_W  load data
- m_ready  out  1  memory request accepted this cycle
- issue_valid  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  REG_W  destination of the issuing instruction
- issue_stall  out  1  issue refused (WAW: issue_reg already pending)
- src1_reg  in  REG_W  decode source 1
- src2_reg  in  REG_W  decode source 2
- src_hazard  out  1  either source pending and not forwarded this cycle
- WriteReg  out  1  register-file write enable
- DstReg  out  REG_W  register-file write index
- DstData  out  DATA_W  register-file write data
- busy  out  NREG  scoreboard pending bits

Behaviour:
- Reset (rst=0 at a clk edge): WriteReg=0, DstReg=0, DstData=0, busy=0, last_grant=M (so A wins the first tie).
- Arbitration is combinational from valids and last_grant.
  - Exactly one request valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - a_ready = grant_A; m_ready = grant_M; at most one is high.
  - Neither valid: no grant.
- A request is accepted when valid & ready; the requester holds valid/reg/data stable until accepted.
- last_grant updates to the granted requester on each acceptance and is unchanged when there is no grant.
- Write stage is registered, 1-cycle latency.
  - Acceptance in cycle N gives WriteReg=1 in cycle N+1, with DstReg/DstData equal to the accepted reg/data.
  - No acceptance in cycle N gives WriteReg=0 in N+1; DstReg/DstData hold their last values.
  - Back-to-back writes are allowed: the port sustains one write per cycle.
- Scoreboard, evaluated at each clk edge:
  - Clear: if WriteReg=1, busy[DstReg] is cleared.
  - Set: if issue_valid & !issue_stall, busy[issue_reg] is set.
  - Same register cleared and set in one cycle: set wins, so the bit ends at 1.
- issue_stall = issue_valid & busy[issue_reg] & !(WriteReg & DstReg==issue_reg). A pending write completing this cycle does not stall.
- src_hazard = OR over src1_reg and src2_reg of (busy[src] & !(WriteReg & DstReg==src)). The register file forwards DstData when reading a register being written, so no hazard is raised for it.
- Writes to a register whose busy bit is 0 are legal; the data is written and busy stays 0.
- Register 0 has no special handling.
- Reset mid-operation: in-flight accepted data is discarded (WriteReg=0 next cycle); requesters must re-present.

Test Plan:
- Reset then a_valid=1, a_reg=3, a_data=0x1234 -> a_ready=1 same cycle; next cycle WriteReg=1, DstReg=3, DstData=0x1234; following cycle WriteReg=0.
- a_valid and m_valid both held high for 4 cycles (a_reg=1/0xAAAA, m_reg=2/0x5555, new data per acceptance) -> grants alternate A,M,A,M; WriteReg=1 for 4 consecutive cycles.
- issue_valid, issue_reg=5 -> busy[5]=1; then src1_reg=5 -> src_hazard=1; m writes reg 5 -> during the WriteReg cycle src_hazard=0; next cycle busy[5]=0.
- busy[7]=1 and issue_reg=7 with no write to 7 -> issue_stall=1, busy unchanged; repeat in the cycle WriteReg=1, DstReg=7 -> issue_stall=0, busy[7] remains 1 after the edge (set wins).
- Accept a write, then assert rst=0 in the next cycle -> WriteReg=0, busy=0, first tie after reset granted to A.
- a_valid held with a_reg=9 while m_valid=0 for 3 cycles, changing data each acceptance -> 3 writes to reg 9 in order, last DstData equal to third value.
